mem_port_arbiter: RTL and testbench

//  Shares one BRAM wrapper port between two masters: M0 (CPU instruction/data port) and M1 (UART bootloader or DMA).

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one BRAM port between M0 (CPU) and M1 (bootloader/DMA)
//
// Ports:
//   i_clock, i_reset           single clock, asynchronous active-high reset
//   i_mX_read/we/addr/din      master X request (held stable until o_mX_ready)
//   o_mX_dout/ready/err        master X read data, completion pulse, timeout flag
//   i_m1_lock                  M1 keeps the grant between transactions while high
//   o_s_read/we/addr/din       slave strobes and payload
//   i_s_dout, i_s_ready        slave read data and completion
//   o_grant                    one-hot {M1,M0}, 00 when idle
module mem_port_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int TIMEOUT    = 64,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_m0_read,
    input  logic [3:0]        i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [31:0]       i_m0_din,
    output logic [31:0]       o_m0_dout,
    output logic              o_m0_ready,
    output logic              o_m0_err,
    input  logic              i_m1_read,
    input  logic [3:0]        i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [31:0]       i_m1_din,
    output logic [31:0]       o_m1_dout,
    output logic              o_m1_ready,
    output logic              o_m1_err,
    input  logic              i_m1_lock,
    output logic              o_s_read,
    output logic [3:0]        o_s_we,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [31:0]       o_s_din,
    input  logic [31:0]       i_s_dout,
    input  logic              i_s_ready,
    output logic [1:0]        o_grant
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic        r_last, w_last_next;
    logic        w_req0, w_req1, w_g0, w_g1, w_req, w_done, w_tmo, w_hold;
    assign w_req0 = i_m0_read | (|i_m0_we);
    assign w_req1 = i_m1_read | (|i_m1_we);
    assign w_g0   = r_state == GNT0;
    assign w_g1   = r_state == GNT1;
    // request of whichever master currently owns the port
    assign w_req  = w_g0 ? w_req0 : (w_g1 & w_req1);
    assign w_done = w_req & i_s_ready;
    assign w_tmo  = (TIMEOUT != 0) && w_req && !i_s_ready && r_cnt == 16'(TIMEOUT - 1);
    assign w_hold = w_g1 & i_m1_lock;
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_last  <= w_last_next;
        end
    end
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = '0;
        w_last_next = r_last;
        if (r_state == IDLE) begin
            if (w_req0 && w_req1)
                w_next = (FIXED_PRIO || !r_last) ? GNT1 : GNT0;
            else if (w_req0)
                w_next = GNT0;
            else if (w_req1)
                w_next = GNT1;
        end else if (w_done || w_tmo) begin
            // a timeout counts as a forced completion for round-robin fairness
            w_last_next = w_g1;
            w_next      = (w_done && w_hold) ? GNT1 : IDLE;
        end else if (!w_req) begin
            // abort, or lock hold where the counter is frozen
            w_next     = w_hold ? GNT1 : IDLE;
            w_cnt_next = w_hold ? r_cnt : '0;
        end else begin
            w_cnt_next = r_cnt + 16'd1;
        end
    end
    always_comb begin
        o_s_read = 1'b0;
        o_s_we   = '0;
        o_s_addr = '0;
        o_s_din  = '0;
        if (w_g0) begin
            o_s_read = i_m0_read & ~w_tmo;
            o_s_we   = i_m0_we & {4{~w_tmo}};
            o_s_addr = i_m0_addr;
            o_s_din  = i_m0_din;
        end else if (w_g1) begin
            o_s_read = i_m1_read & ~w_tmo;
            o_s_we   = i_m1_we & {4{~w_tmo}};
            o_s_addr = i_m1_addr;
            o_s_din  = i_m1_din;
        end
        o_m0_ready = w_g0 & (w_done | w_tmo);
        o_m0_err   = w_g0 & w_tmo;
        o_m0_dout  = (w_g0 & w_done) ? i_s_dout : '0;
        o_m1_ready = w_g1 & (w_done | w_tmo);
        o_m1_err   = w_g1 & w_tmo;
        o_m1_dout  = (w_g1 & w_done) ? i_s_dout : '0;
        o_grant    = {w_g1, w_g0};
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int AW = 18;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic m0_read, m1_read, m0_ready, m1_ready, m0_err, m1_err, m1_lock, s_read, s_ready;
    logic [3:0] m0_we, m1_we, s_we;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [31:0] m0_din, m1_din, m0_dout, m1_dout, s_din, s_dout;
    logic [1:0] grant;
    int checks = 0;
    int errors = 0;
    bit busy = 1'b0;
    bit who = 1'b0;
    int waited = 0;
    bit last_m1 = 1'b1;
    bit [1:0] e_rdy = 2'b00;
    mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TO), .FIXED_PRIO(1'b0)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_m0_read(m0_read), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_din(m0_din),
        .o_m0_dout(m0_dout), .o_m0_ready(m0_ready), .o_m0_err(m0_err),
        .i_m1_read(m1_read), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_din(m1_din),
        .o_m1_dout(m1_dout), .o_m1_ready(m1_ready), .o_m1_err(m1_err), .i_m1_lock(m1_lock),
        .o_s_read(s_read), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_din(s_din),
        .i_s_dout(s_dout), .i_s_ready(s_ready), .o_grant(grant)
    );
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask
    // Model: the port has an owner (or none); a transaction ends on slave ready,
    // on the TO-th unanswered cycle, or when the owner withdraws its request.
    always @(negedge clk) begin : model
        bit [1:0] rq, ex_rdy, ex_err;
        bit r, done, to, ex_read;
        logic [3:0] ex_we;
        logic [AW-1:0] ex_addr;
        logic [31:0] ex_din, ex_d0, ex_d1;
        logic [1:0] ex_g;
        rq = {m1_read || m1_we != 0, m0_read || m0_we != 0};
        {r, done, to, ex_read, ex_we, ex_addr, ex_din, ex_g, ex_rdy, ex_err, ex_d0, ex_d1} = '0;
        if (!rst && busy) begin
            r = rq[who];
            done = r && s_ready;
            to = r && !s_ready && waited + 1 == TO;
            ex_read = (who ? m1_read : m0_read) && !to;
            ex_we = to ? 4'h0 : (who ? m1_we : m0_we);
            ex_addr = who ? m1_addr : m0_addr;
            ex_din = who ? m1_din : m0_din;
            ex_g = who ? 2'b10 : 2'b01;
            ex_rdy[who] = done || to;
            ex_err[who] = to;
            if (done && !who) ex_d0 = s_dout;
            if (done && who) ex_d1 = s_dout;
        end
        chk("s_read", s_read, ex_read);
        chk("s_we", s_we, ex_we);
        chk("s_addr", s_addr, ex_addr);
        chk("s_din", s_din, ex_din);
        chk("grant", grant, ex_g);
        chk("m0_ready", m0_ready, ex_rdy[0]);
        chk("m1_ready", m1_ready, ex_rdy[1]);
        chk("m0_err", m0_err, ex_err[0]);
        chk("m1_err", m1_err, ex_err[1]);
        chk("m0_dout", m0_dout, ex_d0);
        chk("m1_dout", m1_dout, ex_d1);
        e_rdy = ex_rdy;
        if (rst) begin
            busy = 0; waited = 0; last_m1 = 1;
        end else if (!busy) begin
            waited = 0;
            if (rq != 0) begin
                busy = 1;
                who = (rq == 2'b11) ? !last_m1 : rq[1];
            end
        end else if (done || to) begin
            last_m1 = who;
            busy = done && who && m1_lock;
            waited = 0;
        end else if (!r) begin
            if (!(who && m1_lock)) begin busy = 0; waited = 0; end
        end else begin
            waited++;
        end
    end
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic clr;
        {m0_read, m0_we, m0_addr, m0_din, m1_read, m1_we, m1_addr, m1_din, m1_lock, s_ready, s_dout} = '0;
    endtask
    initial begin
        bit [1:0] pend, prd;
        logic [3:0] pwe [2];
        logic [AW-1:0] pad [2];
        logic [31:0] pdi [2];
        logic [1:0] seq [7];
        int p;
        clr;
        m0_read = 1; m1_we = 4'hF;
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_read", s_read, 1'b0);
        chk("rst_s_we", s_we, 4'h0);
        chk("rst_m0_ready", m0_ready, 1'b0);
        clr;
        cyc; rst = 0;
        cyc;
        // single M0 read, slave answers on the second grant cycle
        m0_read = 1; m0_addr = 18'h10;
        @(negedge clk); chk("t1_latency_grant", grant, 2'b00); chk("t1_latency_read", s_read, 1'b0);
        cyc;
        @(negedge clk); chk("t1_grant", grant, 2'b01); chk("t1_s_read", s_read, 1'b1); chk("t1_addr", s_addr, 18'h10);
        cyc; s_ready = 1; s_dout = 32'hDEADBEEF;
        @(negedge clk); chk("t1_ready", m0_ready, 1'b1); chk("t1_dout", m0_dout, 32'hDEADBEEF); chk("t1_m1_ready", m1_ready, 1'b0);
        cyc; m0_read = 0; s_ready = 0;
        @(negedge clk); chk("t1_idle", grant, 2'b00); chk("t1_ready_once", m0_ready, 1'b0);
        // round-robin with both masters pending, M0 first after reset
        cyc; rst = 1;
        cyc; rst = 0;
        cyc; m0_read = 1; m1_read = 1; s_ready = 1;
        @(negedge clk); chk("t2_first", grant, 2'b00);
        seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        for (int i = 0; i < 7; i++) begin
            cyc;
            @(negedge clk); chk("t2_rr", grant, seq[i]);
        end
        cyc; clr;
        cyc;
        // locked 4-word M1 burst while M0 waits
        m1_lock = 1; m1_we = 4'hF; m1_addr = 0; m1_din = 32'h11;
        @(negedge clk); chk("t3_idle", grant, 2'b00);
        cyc; m0_read = 1; s_ready = 1;
        @(negedge clk); chk("t3_g0", grant, 2'b10); chk("t3_we", s_we, 4'hF); chk("t3_rdy0", m1_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            cyc; m1_addr = AW'(i); m1_din = 32'h11 + i; m1_lock = (i != 3);
            @(negedge clk); chk("t3_burst_grant", grant, 2'b10); chk("t3_burst_addr", s_addr, AW'(i));
            chk("t3_burst_rdy", m1_ready, 1'b1); chk("t3_m0_wait", m0_ready, 1'b0);
        end
        cyc; m1_we = 0; m1_lock = 0; s_ready = 0;
        @(negedge clk); chk("t3_gap", grant, 2'b00);
        cyc; s_ready = 1;
        @(negedge clk); chk("t3_m0_grant", grant, 2'b01); chk("t3_m0_ready", m0_ready, 1'b1);
        cyc; clr;
        @(negedge clk); chk("t3_end", grant, 2'b00);
        // timeout on the eighth unanswered grant cycle
        cyc; m0_read = 1; m0_addr = 18'h3; s_dout = 32'hCAFEF00D;
        for (int k = 1; k <= 8; k++) begin
            cyc;
            @(negedge clk);
            chk("t4_grant", grant, 2'b01);
            chk("t4_ready", m0_ready, k == 8);
            chk("t4_err", m0_err, k == 8);
            chk("t4_read", s_read, k != 8);
            chk("t4_dout", m0_dout, 32'h0);
        end
        cyc; m0_read = 0;
        @(negedge clk); chk("t4_idle", grant, 2'b00);
        // M0 abort, then M1 gets the port
        cyc; m0_read = 1;
        cyc;
        @(negedge clk); chk("t5_g0", grant, 2'b01);
        cyc; m0_read = 0; m1_read = 1;
        @(negedge clk); chk("t5_no_ready", m0_ready, 1'b0);
        cyc;
        cyc; s_ready = 1;
        @(negedge clk); chk("t5_g1", grant, 2'b10); chk("t5_m1_ready", m1_ready, 1'b1);
        cyc; clr;
        // asynchronous reset in the middle of an M1 write
        cyc; m1_we = 4'hF; m1_addr = 18'h7; m1_din = 32'h55;
        cyc;
        @(negedge clk); chk("t6_g1", grant, 2'b10); chk("t6_we", s_we, 4'hF);
        #2 rst = 1;
        #1; chk("t6_we_async", s_we, 4'h0); chk("t6_grant_async", grant, 2'b00); chk("t6_no_ready", m1_ready, 1'b0);
        cyc; clr;
        cyc; rst = 0;
        // randomized traffic, the model process checks every cycle
        pend = 0; prd = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc;
            rst = (c % 900 == 450);
            p = ((c / 500) % 2 == 1) ? 16 : 3;
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && e_rdy[i]) pend[i] = 0;
                if (!pend[i]) begin
                    if ($urandom % 3 == 0) begin
                        pend[i] = 1;
                        prd[i] = $urandom_range(0, 1);
                        pwe[i] = prd[i] ? 4'h0 : 4'($urandom_range(1, 15));
                        pad[i] = AW'($urandom);
                        pdi[i] = $urandom;
                    end
                end else if ($urandom % 50 == 0) begin
                    pend[i] = 0;
                end
            end
            m0_read = pend[0] && prd[0]; m0_we = pend[0] ? pwe[0] : 4'h0; m0_addr = pad[0]; m0_din = pdi[0];
            m1_read = pend[1] && prd[1]; m1_we = pend[1] ? pwe[1] : 4'h0; m1_addr = pad[1]; m1_din = pdi[1];
            if ($urandom % 16 == 0) m1_lock = ~m1_lock;
            s_dout = $urandom;
            s_ready = ($urandom % p == 0) && !(busy && !pend[who]);
        end
        cyc; clr; rst = 0;
        cyc;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
